// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for a 5-stage MIPS pipeline.
// It drives the load enables and bubble (flush) controls of the PC, IF_ID,
// ID_EXE, EXE_MEM and MEM_WB registers. It handles these cases:
//   - load-use stalls
//   - taken-branch flushes, with the branch resolved in MEM
//   - data-memory wait states, with a timeout
// It also keeps a saturating stall-cycle counter.
//
// Ports:
//   clock_i, resetn_i              clock, async active-low reset
//   id_rs_i, id_rt_i               source registers of the instruction in ID
//   ex_mem_read_i, ex_rt_i         load in EXE and its destination register
//   branch_taken_i                 branch in MEM resolved taken
//   mem_access_i, mem_ready_i      data-memory access in MEM / completion
//   *_en_o                         register load enables
//   *_flush_o                      load zeros (bubble) at next edge; overrides enable
//   ctrl_state_o                   00 RUN, 01 MEM_WAIT, 10 ERROR
//   timeout_err_o                  sticky memory-timeout flag
//   stall_cycles_o                 saturating count of pc_en=0 cycles outside ERROR
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_access_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_exe_en_o,
  output logic             exe_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_exe_flush_o,
  output logic             exe_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       ctrl_state_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StError   = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic mstall;
  logic luse;

  assign mstall = mem_access_i & ~mem_ready_i;
  assign luse   = ex_mem_read_i & (ex_rt_i != 5'd0) &
                  ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

  // Pipeline controls. Priority is mstall > branch > load-use; a load-use
  // hazard seen during a memory stall is simply re-evaluated once ready.
  always_comb begin
    pc_en_o         = 1'b1;
    if_id_en_o      = 1'b1;
    id_exe_en_o     = 1'b1;
    exe_mem_en_o    = 1'b1;
    mem_wb_en_o     = 1'b1;
    if_id_flush_o   = 1'b0;
    id_exe_flush_o  = 1'b0;
    exe_mem_flush_o = 1'b0;
    mem_wb_flush_o  = 1'b0;
    if (!resetn_i) begin
      // Hold the whole pipeline in bubbles while reset is asserted.
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      id_exe_en_o     = 1'b0;
      exe_mem_en_o    = 1'b0;
      mem_wb_en_o     = 1'b0;
      if_id_flush_o   = 1'b1;
      id_exe_flush_o  = 1'b1;
      exe_mem_flush_o = 1'b1;
      mem_wb_flush_o  = 1'b1;
    end else if (state_q == StError) begin
      pc_en_o      = 1'b0;
      if_id_en_o   = 1'b0;
      id_exe_en_o  = 1'b0;
      exe_mem_en_o = 1'b0;
      mem_wb_en_o  = 1'b0;
    end else if (mstall) begin
      // Freeze the front of the pipe; MEM_WB takes a bubble.
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_exe_en_o    = 1'b0;
      exe_mem_en_o   = 1'b0;
      mem_wb_flush_o = 1'b1;
    end else if (branch_taken_i) begin
      // PC loads the target; the three younger instructions are squashed.
      if_id_flush_o   = 1'b1;
      id_exe_flush_o  = 1'b1;
      exe_mem_flush_o = 1'b1;
    end else if (luse) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_exe_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_err_d  = timeout_err_q;
    stall_cycles_d = stall_cycles_q;
    unique case (state_q)
      StRun: begin
        if (mstall) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      StMemWait: begin
        if (mstall && (wait_cnt_q == 8'(WAIT_MAX))) begin
          state_d       = StError;
          timeout_err_d = 1'b1;
        end else if (mstall) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end
      end
      StError: begin
        timeout_err_d = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
    if ((state_q != StError) && !pc_en_o && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q        <= StRun;
      wait_cnt_q     <= 8'd0;
      timeout_err_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_err_q  <= timeout_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ctrl_state_o   = state_q;
  assign timeout_err_o  = timeout_err_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule
